// File: rtl/sum_report_uart_tx_if.sv
// Request handshake carrying a sum to report over the UART.
// master drives sum_in/sum_valid; slave returns sum_ready.
interface sum_report_uart_tx_if #(
  parameter int SUM_W = 5
);
  logic [SUM_W-1:0] sum_in;
  logic             sum_valid;
  logic             sum_ready;

  modport master (
    output sum_in,
    output sum_valid,
    input  sum_ready
  );

  modport slave (
    input  sum_in,
    input  sum_valid,
    output sum_ready
  );
endinterface

// File: rtl/sum_report_uart_tx.sv
// Formats a latched sum as two ASCII decimal digits plus CR LF and sends
// the 4 bytes as 8N1 UART frames. Ports: clk, reset_n, req (slave), uart_txd, uart_tx_busy.
module sum_report_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SUM_W        = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  sum_report_uart_tx_if.slave req,
  output logic                uart_txd,
  output logic                uart_tx_busy
);

  localparam int BW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int MAXT = ((1 << SUM_W) - 1) / 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [SUM_W-1:0] sum_q;
  logic [1:0]       byte_idx;
  logic [2:0]       bit_idx;
  logic [BW-1:0]    baud;
  logic [7:0]       shreg;
  logic             ready_q;

  logic [SUM_W-1:0] rem;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic [7:0]       tx_byte;
  logic             baud_last;

  assign req.sum_ready = ready_q;
  assign baud_last     = (baud == BW'(CLKS_PER_BIT - 1));

  // Decimal split by repeated constant subtraction of ten.
  always_comb begin
    rem  = sum_q;
    tens = '0;
    for (int i = 0; i < MAXT; i++) begin
      if (rem >= SUM_W'(10)) begin
        rem  = rem - SUM_W'(10);
        tens = tens + 4'd1;
      end
    end
    ones = 4'(rem);
  end

  always_comb begin
    tx_byte = 8'h0A;
    case (byte_idx)
      2'd0:    tx_byte = 8'h30 + {4'd0, tens};
      2'd1:    tx_byte = 8'h30 + {4'd0, ones};
      2'd2:    tx_byte = 8'h0D;
      default: tx_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sum_q        <= '0;
      byte_idx     <= '0;
      bit_idx      <= '0;
      baud         <= '0;
      shreg        <= '0;
      ready_q      <= 1'b1;
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req.sum_valid && ready_q) begin
            sum_q        <= req.sum_in;
            state        <= START;
            byte_idx     <= '0;
            baud         <= '0;
            uart_txd     <= 1'b0;
            uart_tx_busy <= 1'b1;
            ready_q      <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            // Byte is loaded here so byte_idx has settled for this frame.
            baud     <= '0;
            state    <= DATA;
            bit_idx  <= '0;
            uart_txd <= tx_byte[0];
            shreg    <= {1'b0, tx_byte[7:1]};
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              uart_txd <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shreg[0];
              shreg    <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud <= '0;
            if (byte_idx == 2'd3) begin
              state        <= IDLE;
              uart_tx_busy <= 1'b0;
              ready_q      <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= START;
              uart_txd <= 1'b0;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_report_uart_tx.sv
// Self-checking bench: decodes the serial line and compares each message
// against an arithmetic model of the ASCII report.
module tb_sum_report_uart_tx;

  localparam int CPB = 4;
  localparam int MSG = 40 * CPB;

  logic clk;
  logic reset_n;
  logic uart_txd;
  logic uart_tx_busy;

  int n_checks;
  int n_fail;

  logic rec_tx [0:MSG-1];
  int   rec_busy;
  int   rec_rdy;

  sum_report_uart_tx_if #(.SUM_W(5)) ifc ();

  sum_report_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SUM_W(5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(ifc.slave),
    .uart_txd(uart_txd),
    .uart_tx_busy(uart_tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_byte(input int s, input int k);
    case (k)
      0:       return 8'h30 + 8'(s / 10);
      1:       return 8'h30 + 8'(s % 10);
      2:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  function automatic logic model_bit(input int s, input int c);
    logic [7:0] b;
    int p;
    b = model_byte(s, c / 40 / CPB * 0 + c / (10 * CPB));
    p = (c % (10 * CPB)) / CPB;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  function automatic int wave_errs(input int s);
    int e = 0;
    for (int c = 0; c < MSG; c++)
      if (rec_tx[c] !== model_bit(s, c)) e++;
    return e;
  endfunction

  function automatic logic [7:0] rx_byte(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++)
      b[j] = rec_tx[k * 10 * CPB + (j + 1) * CPB + CPB / 2];
    return b;
  endfunction

  task automatic record(input int inj_at, input int inj_sum);
    rec_busy = 0;
    rec_rdy  = 0;
    for (int c = 0; c < MSG; c++) begin
      rec_tx[c] = uart_txd;
      if (uart_tx_busy === 1'b1) rec_busy++;
      if (ifc.sum_ready === 1'b1) rec_rdy++;
      if (inj_at >= 0) begin
        if (c == inj_at) begin
          ifc.sum_valid = 1'b1;
          ifc.sum_in    = 5'(inj_sum);
        end
        if (c == inj_at + 1) ifc.sum_valid = 1'b0;
        if (c == 80) ifc.sum_in = 5'($urandom_range(0, 31));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    ifc.sum_valid = 1'b0;
    ifc.sum_in    = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({uart_txd, uart_tx_busy, ifc.sum_ready} !== 3'b101) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: txd/busy/ready=%b expected 101",
                 i, {uart_txd, uart_tx_busy, ifc.sum_ready});
      end
    end
  endtask

  task automatic test_message(input int s, input string tag);
    logic [7:0] got;
    int e;
    ifc.sum_in    = 5'(s);
    ifc.sum_valid = 1'b1;
    @(negedge clk);
    ifc.sum_valid = 1'b0;
    record(-1, 0);
    for (int k = 0; k < 4; k++) begin
      got = rx_byte(k);
      n_checks++;
      if (got !== model_byte(s, k)) begin
        n_fail++;
        $display("FAIL %s byte%0d: got %h expected %h", tag, k, got, model_byte(s, k));
      end
    end
    e = wave_errs(s);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL %s waveform: %0d bad cycles expected 0", tag, e);
    end
    n_checks++;
    if (rec_busy !== MSG || rec_rdy !== 0) begin
      n_fail++;
      $display("FAIL %s busy_len: busy=%0d ready=%0d expected %0d/0", tag, rec_busy, rec_rdy, MSG);
    end
    n_checks++;
    if ({uart_txd, uart_tx_busy, ifc.sum_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL %s done: txd/busy/ready=%b expected 101", tag,
               {uart_txd, uart_tx_busy, ifc.sum_ready});
    end
  endtask

  task automatic test_busy_request();
    int e;
    int idle_bad = 0;
    ifc.sum_in    = 5'd14;
    ifc.sum_valid = 1'b1;
    @(negedge clk);
    ifc.sum_valid = 1'b0;
    record(50, 3);
    e = wave_errs(14);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL busy_req waveform: %0d bad cycles expected 0", e);
    end
    for (int i = 0; i < 60; i++) begin
      if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) idle_bad++;
      @(negedge clk);
    end
    n_checks++;
    if (idle_bad !== 0) begin
      n_fail++;
      $display("FAIL busy_req no_second: %0d active cycles expected 0", idle_bad);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    int idle_bad = 0;
    ifc.sum_in    = 5'd22;
    ifc.sum_valid = 1'b1;
    @(negedge clk);
    record(-1, 0);
    e = wave_errs(22);
    n_checks++;
    if (e !== 0 || rec_busy !== MSG) begin
      n_fail++;
      $display("FAIL held msg1: bad=%0d busy=%0d expected 0/%0d", e, rec_busy, MSG);
    end
    n_checks++;
    if ({uart_txd, uart_tx_busy, ifc.sum_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL held gap: txd/busy/ready=%b expected 101",
               {uart_txd, uart_tx_busy, ifc.sum_ready});
    end
    @(negedge clk);
    record(-1, 0);
    ifc.sum_valid = 1'b0;
    e = wave_errs(22);
    n_checks++;
    if (e !== 0 || rec_busy !== MSG) begin
      n_fail++;
      $display("FAIL held msg2: bad=%0d busy=%0d expected 0/%0d", e, rec_busy, MSG);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_tx_busy !== 1'b0) idle_bad++;
    end
    n_checks++;
    if (idle_bad !== 0) begin
      n_fail++;
      $display("FAIL held release: %0d busy cycles expected 0", idle_bad);
    end
  endtask

  task automatic test_reset_mid();
    ifc.sum_in    = 5'd27;
    ifc.sum_valid = 1'b1;
    @(negedge clk);
    ifc.sum_valid = 1'b0;
    repeat (57) @(negedge clk);
    n_checks++;
    if (uart_txd !== model_bit(27, 57)) begin
      n_fail++;
      $display("FAIL rst_mid pre: txd=%b expected %b", uart_txd, model_bit(27, 57));
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({uart_txd, uart_tx_busy, ifc.sum_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL rst_mid async: txd/busy/ready=%b expected 101",
               {uart_txd, uart_tx_busy, ifc.sum_ready});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({uart_txd, uart_tx_busy, ifc.sum_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL rst_mid idle: txd/busy/ready=%b expected 101",
               {uart_txd, uart_tx_busy, ifc.sum_ready});
    end
    test_message(8, "after_rst");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_message(27, "basic27");
    test_message(0, "bound0");
    test_message(31, "bound31");
    test_message(9, "bound9");
    test_busy_request();
    test_back_to_back();
    test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      test_message(int'($urandom_range(0, 31)), "random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_report_uart_tx.md
Name: sum_report_uart_tx

Overview:
Downstream stage of the sum/latch datapath. It takes a latched 5-bit sum, formats it as two ASCII decimal digits followed by CR LF, and serializes the 4 bytes as 8N1 UART frames on uart_txd. It contains its own baud counter and frame state machine. Its uart_txd and uart_tx_busy outputs drive the top-level UART pins directly.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (434 gives 115200 baud at 50 MHz); legal minimum 2
SUM_W, 5, sum_in width; covers 0..31, the sum of two 4-bit operands plus margin

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
sum_in  input  SUM_W  unsigned sum to report; sampled only on accept
sum_valid  input  1  request to send sum_in; level or pulse
sum_ready  output  1  high when a new request is accepted
uart_txd  output  1  serial line, idle high
uart_tx_busy  output  1  high while any frame of the message is on the line

Behaviour:
- Reset values (asynchronous on reset_n low, held while low): uart_txd=1, uart_tx_busy=0, sum_ready=1, state=IDLE, byte index=0, bit counter=0, baud counter=0.
- Accept: a request is accepted on a rising edge where sum_valid=1 and sum_ready=1.
  - At that same edge sum_in is captured, the state goes to START, uart_txd goes 0 (registered), uart_tx_busy goes 1, and sum_ready goes 0.
- Formatting, computed from the captured value:
  - tens = sum/10, ones = sum%10.
  - Byte0 = 0x30+tens, byte1 = 0x30+ones, byte2 = 0x0D, byte3 = 0x0A.
  - Leading zero is always sent (sum 5 gives "05").
  - SUM_W=5 gives tens in 0..3. Division uses constant compare/subtract; no divider IP.
- Frame format: 8N1, LSB first.
  - Each bit is held for exactly CLKS_PER_BIT cycles, counted by the baud counter from 0 to CLKS_PER_BIT-1.
  - Bit order: start (0), d0..d7, stop (1).
- State machine:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START of the next byte when byte index < 3. The byte index increments and there is no idle gap between frames.
  - STOP -> IDLE when byte index = 3.
- Completion: at the edge ending the final stop bit, uart_tx_busy goes 0, sum_ready goes 1, and uart_txd stays 1.
  - Total busy time is exactly 40*CLKS_PER_BIT cycles.
  - A new request may be accepted in the cycle after busy falls, i.e. on the first edge where sum_ready=1.
- Requests while busy: sum_valid is ignored and is not queued. sum_in changes while busy do not affect the message in flight.
- Held request: if sum_valid is held high continuously, a new message starts on the first edge after completion (back-to-back messages, 1 idle-high cycle between them).
- Reset mid-message: uart_txd returns to 1 immediately (asynchronously) and the partial frame is abandoned. After release the block is in IDLE with ready=1, and the partial message is not resumed.
- uart_txd is driven from a flop; it is never combinational from state.

Test Plan:
- Use CLKS_PER_BIT=4 for all scenarios.
- Reset then idle: assert reset_n=0 for 3 cycles, release, and wait 20 cycles -> uart_txd=1, uart_tx_busy=0, sum_ready=1 throughout.
- Basic message: sum_in=27 with a 1-cycle sum_valid -> line decodes to bytes 0x32, 0x37, 0x0D, 0x0A. Each bit is 4 cycles wide, busy is high for exactly 160 cycles, and ready rises on the same edge busy falls.
- Boundary values: sum_in=0 -> 0x30, 0x30, 0x0D, 0x0A. sum_in=31 -> 0x33, 0x31, 0x0D, 0x0A. sum_in=9 -> 0x30, 0x39, 0x0D, 0x0A.
- Request during busy: send 14, then pulse sum_valid with sum_in=3 at cycle 50 and change sum_in mid-message -> only "14\r\n" is transmitted and no second message follows.
- Held valid: keep sum_valid=1 with sum_in=22 -> two consecutive "22\r\n" messages, each separated by exactly 1 idle-high cycle where ready=1.
- Reset mid-frame: assert reset_n=0 during the data bits of byte1 -> uart_txd=1 the same cycle and busy=0. A new request for 8 after release yields a clean "08\r\n".
